// File: rtl/dmem_req_ctrl_if.sv
// Data-memory command/response bus.
// Master is the core-side controller, slave is the memory.
interface dmem_req_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              valid;
  logic              wen;
  logic              byte_nw;
  logic              yumi;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              ack;

  modport master (
    output addr,
    output wdata,
    output valid,
    output wen,
    output byte_nw,
    output yumi,
    input  rdata,
    input  rvalid,
    input  ack
  );

  modport slave (
    input  addr,
    input  wdata,
    input  valid,
    input  wen,
    input  byte_nw,
    input  yumi,
    output rdata,
    output rvalid,
    output ack
  );
endinterface

// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: one access at a time,
// valid/yumi handshake, pipeline stall, load align, sticky error.
module dmem_req_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            req_valid_i,
  input  logic [1:0]      req_op_i,
  input  logic [31:0]     req_addr_i,
  input  logic [31:0]     req_wdata_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [31:0]     rdata_o,
  output logic            err_o,
  output logic [1:0]      state_o,
  dmem_req_ctrl_if.master mem
);

  localparam logic [CNT_W-1:0] TMO =
    CNT_W'(TIMEOUT_CYC);
  localparam bit TMO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SENT,
    S_ACKED,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [CNT_W-1:0]  cnt_d;
  logic [31:0]       wdata_d;
  logic [31:0]       rdata_d;
  logic [7:0]        lane;

  logic s_idle;
  logic s_sent;
  logic s_acked;
  logic s_done;
  logic s_err;
  logic misaligned;
  logic is_store;
  logic is_byte;
  logic yumi;
  logic complete;
  logic timeout;
  logic unused_addr_hi;

  assign unused_addr_hi = ^req_addr_i[31:ADDR_W];

  assign s_idle  = (state_q == S_IDLE);
  assign s_sent  = (state_q == S_SENT);
  assign s_acked = (state_q == S_ACKED);
  assign s_done  = (state_q == S_DONE);
  assign s_err   = (state_q == S_ERR);

  // Word ops (op[0]=0) need a 4-byte aligned address.
  assign misaligned =
    ~req_op_i[0] & (req_addr_i[1:0] != 2'b00);

  assign is_store = op_q[1];
  assign is_byte  = op_q[0];

  // Read data is consumed only when the command
  // has been (or is being) accepted.
  assign yumi =
    (s_sent & mem.ack & ~is_store & mem.rvalid)
    | (s_acked & mem.rvalid);

  assign complete =
    (s_sent & mem.ack & is_store) | yumi;

  // Fires on the cycle that would be the
  // TIMEOUT_CYC-th spent waiting; completion wins.
  assign cnt_d   = cnt_q + CNT_W'(1);
  assign timeout = TMO_EN && (cnt_d == TMO);

  // SB drives the byte onto every lane.
  assign wdata_d = req_op_i[0]
                 ? {4{req_wdata_i[7:0]}}
                 : req_wdata_i;

  // Little-endian byte lane pick for LBU.
  always_comb begin
    lane = mem.rdata[7:0];
    unique case (1'b1)
      addr_q[1:0] == 2'd0: lane = mem.rdata[7:0];
      addr_q[1:0] == 2'd1: lane = mem.rdata[15:8];
      addr_q[1:0] == 2'd2: lane = mem.rdata[23:16];
      addr_q[1:0] == 2'd3: lane = mem.rdata[31:24];
      default:             lane = mem.rdata[7:0];
    endcase
  end

  assign rdata_d = is_byte ? {24'b0, lane} : mem.rdata;

  // Request FSM with latched command and timeout counter.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            if (misaligned) begin
              state_q <= S_ERR;
            end else begin
              op_q    <= req_op_i;
              addr_q  <= req_addr_i[ADDR_W-1:0];
              wdata_q <= wdata_d;
              cnt_q   <= '0;
              state_q <= S_SENT;
            end
          end
        end
        S_SENT: begin
          cnt_q <= cnt_d;
          if (complete) begin
            if (yumi) rdata_q <= rdata_d;
            state_q <= S_DONE;
          end else if (timeout) begin
            state_q <= S_ERR;
          end else if (mem.ack) begin
            state_q <= S_ACKED;
          end
        end
        S_ACKED: begin
          cnt_q <= cnt_d;
          if (yumi) begin
            rdata_q <= rdata_d;
            state_q <= S_DONE;
          end else if (timeout) begin
            state_q <= S_ERR;
          end
        end
        S_DONE: state_q <= S_IDLE;
        S_ERR:  state_q <= S_ERR;
        default: state_q <= S_ERR;
      endcase
    end
  end

  // In IDLE the stall must rise with the request itself.
  assign stall_o = s_idle
                 ? (req_valid_i & ~misaligned)
                 : ~s_done;

  assign done_o  = s_done;
  assign err_o   = s_err;
  assign rdata_o = rdata_q;
  assign state_o = {s_err, ~s_idle};

  assign mem.addr    = addr_q;
  assign mem.wdata   = wdata_q;
  assign mem.valid   = s_sent;
  assign mem.wen     = s_sent & is_store;
  assign mem.byte_nw = s_sent & is_byte;
  assign mem.yumi    = yumi;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Bench for dmem_req_ctrl: per-cycle control checks
// plus a load-data scoreboard popped on done_o.
module tb_dmem_req_ctrl;

  logic        clk;
  logic        n_reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [1:0]  state_o;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_rdata = '0;

  dmem_req_ctrl_if #(.ADDR_W(12)) m ();

  dmem_req_ctrl #(
    .ADDR_W(12),
    .TIMEOUT_CYC(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .req_valid_i(req_valid),
    .req_op_i(req_op),
    .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .stall_o(stall_o),
    .done_o(done_o),
    .rdata_o(rdata_o),
    .err_o(err_o),
    .state_o(state_o),
    .mem(m.master)
  );

  // {stall, done, err, state[1:0], valid, wen, byte, yumi}
  logic [8:0] ctl;
  assign ctl = {stall_o, done_o, err_o, state_o,
                m.valid, m.wen, m.byte_nw, m.yumi};

  localparam logic [8:0] C_ZERO  = 9'b0_0_0_00_0000;
  localparam logic [8:0] C_REQ   = 9'b1_0_0_00_0000;
  localparam logic [8:0] C_S_LW  = 9'b1_0_0_01_1000;
  localparam logic [8:0] C_S_LB  = 9'b1_0_0_01_1010;
  localparam logic [8:0] C_S_SW  = 9'b1_0_0_01_1100;
  localparam logic [8:0] C_S_SB  = 9'b1_0_0_01_1110;
  localparam logic [8:0] C_ACKED = 9'b1_0_0_01_0000;
  localparam logic [8:0] C_DONE  = 9'b0_1_0_01_0000;
  localparam logic [8:0] C_ERR   = 9'b1_0_1_11_0000;
  localparam logic [8:0] C_YUMI  = 9'b0_0_0_00_0001;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  // Scoreboard: every done_o must match the oldest expectation.
  always @(negedge clk) begin
    if (n_reset && done_o) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_done got unexpected done_o want none");
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rdata_o !== e) begin
          errors++;
          $display("FAIL sb_rdata got %h want %h", rdata_o, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    req_valid = 1'b0;
    m.ack     = 1'b0;
    m.rvalid  = 1'b0;
    n_reset   = 1'b0;
    #1;
    vectors++;
    if (ctl !== C_ZERO) begin
      errors++;
      $display("FAIL %s_rst_ctl got %b want %b", nm, ctl, C_ZERO);
    end
    vectors++;
    if (rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL %s_rst_rdata got %h want 0", nm, rdata_o);
    end
    @(negedge clk);
    n_reset = 1'b1;
    exp_q.delete();
    model_rdata = '0;
    cyc();
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (ctl !== C_ZERO) begin
      errors++;
      $display("FAIL reset_ctl got %b want %b", ctl, C_ZERO);
    end
    vectors++;
    if ({rdata_o, m.addr, m.wdata} !== 76'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h want 0",
               rdata_o, m.addr, m.wdata);
    end
    @(negedge clk);
    n_reset = 1'b1;
    cyc();
    @(negedge clk);
    vectors++;
    if (ctl !== C_ZERO) begin
      errors++;
      $display("FAIL reset_idle got %b want %b", ctl, C_ZERO);
    end
    cyc();
  endtask

  task automatic test_sw();
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_addr  = 32'h010;
    req_wdata = 32'hDEADBEEF;
    exp_q.push_back(model_rdata);
    @(negedge clk);
    vectors++;
    if (ctl !== C_REQ) begin
      errors++;
      $display("FAIL sw_req got %b want %b", ctl, C_REQ);
    end
    cyc();
    m.ack = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== C_S_SW) begin
      errors++;
      $display("FAIL sw_sent got %b want %b", ctl, C_S_SW);
    end
    vectors++;
    if (m.addr !== 12'h010 || m.wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_bus got %h/%h want 010/deadbeef",
               m.addr, m.wdata);
    end
    cyc();
    m.ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== C_DONE) begin
      errors++;
      $display("FAIL sw_done got %b want %b", ctl, C_DONE);
    end
    cyc();
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== C_ZERO) begin
      errors++;
      $display("FAIL sw_idle got %b want %b", ctl, C_ZERO);
    end
    cyc();
  endtask

  task automatic test_lw_wait();
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_addr  = 32'h020;
    req_wdata = 32'h0;
    model_rdata = 32'h12345678;
    exp_q.push_back(model_rdata);
    cyc();
    m.ack = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== C_S_LW) begin
      errors++;
      $display("FAIL lw_sent got %b want %b", ctl, C_S_LW);
    end
    cyc();
    m.ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== C_ACKED) begin
        errors++;
        $display("FAIL lw_acked%0d got %b want %b", i, ctl, C_ACKED);
      end
      cyc();
    end
    m.rvalid = 1'b1;
    m.rdata  = 32'h12345678;
    @(negedge clk);
    vectors++;
    if (ctl !== (C_ACKED | C_YUMI)) begin
      errors++;
      $display("FAIL lw_yumi got %b want %b", ctl, C_ACKED | C_YUMI);
    end
    cyc();
    m.rvalid = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== C_DONE) begin
      errors++;
      $display("FAIL lw_done got %b want %b", ctl, C_DONE);
    end
    cyc();
  endtask

  task automatic test_lbu();
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = 32'h023;
    model_rdata = 32'h000000AA;
    exp_q.push_back(model_rdata);
    cyc();
    m.ack    = 1'b1;
    m.rvalid = 1'b1;
    m.rdata  = 32'hAABBCCDD;
    @(negedge clk);
    vectors++;
    if (ctl !== (C_S_LB | C_YUMI) || m.addr !== 12'h023) begin
      errors++;
      $display("FAIL lbu_sent got %b/%h want %b/023",
               ctl, m.addr, C_S_LB | C_YUMI);
    end
    cyc();
    m.ack = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== C_DONE) begin
      errors++;
      $display("FAIL lbu_done got %b want %b", ctl, C_DONE);
    end
    cyc();
    @(negedge clk);
    vectors++;
    if (ctl !== C_ZERO) begin
      errors++;
      $display("FAIL lbu_idle_noyumi got %b want %b", ctl, C_ZERO);
    end
    cyc();
    m.rvalid = 1'b0;
  endtask

  task automatic test_sb();
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_addr  = 32'h005;
    req_wdata = 32'hABCD12E7;
    exp_q.push_back(model_rdata);
    cyc();
    m.ack = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== C_S_SB) begin
      errors++;
      $display("FAIL sb_sent got %b want %b", ctl, C_S_SB);
    end
    vectors++;
    if (m.wdata !== 32'hE7E7E7E7 || m.addr !== 12'h005) begin
      errors++;
      $display("FAIL sb_bus got %h/%h want e7e7e7e7/005",
               m.wdata, m.addr);
    end
    cyc();
    m.ack = 1'b0;
    req_valid = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [31:0] wd;
    logic [31:0] ad;
    logic [8:0]  es;
    logic [31:0] ew;
    for (int i = 0; i < 12; i++) begin
      rd = $urandom;
      wd = $urandom;
      req_op = 2'(i % 4);
      ad = {20'h0, 4'(i), 8'h40};
      if (req_op[0]) ad[1:0] = 2'(i / 4 + i);
      req_valid = 1'b1;
      req_addr  = ad;
      req_wdata = wd;
      ew = wd;
      unique case (req_op)
        2'b00: begin
          es = C_S_LW | C_YUMI;
          model_rdata = rd;
        end
        2'b01: begin
          es = C_S_LB | C_YUMI;
          model_rdata = (rd >> (8 * ad[1:0])) & 32'hFF;
        end
        2'b10: es = C_S_SW;
        default: begin
          es = C_S_SB;
          ew = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        end
      endcase
      exp_q.push_back(model_rdata);
      @(negedge clk);
      vectors++;
      if (ctl !== C_REQ) begin
        errors++;
        $display("FAIL b2b_req%0d got %b want %b", i, ctl, C_REQ);
      end
      cyc();
      m.ack    = 1'b1;
      m.rvalid = 1'b1;
      m.rdata  = rd;
      @(negedge clk);
      vectors++;
      if (ctl !== es || m.addr !== ad[11:0]) begin
        errors++;
        $display("FAIL b2b_sent%0d got %b/%h want %b/%h",
                 i, ctl, m.addr, es, ad[11:0]);
      end
      if (req_op[1]) begin
        vectors++;
        if (m.wdata !== ew) begin
          errors++;
          $display("FAIL b2b_wdata%0d got %h want %h",
                   i, m.wdata, ew);
        end
      end
      cyc();
      m.ack    = 1'b0;
      m.rvalid = 1'b0;
      @(negedge clk);
      vectors++;
      if (ctl !== C_DONE) begin
        errors++;
        $display("FAIL b2b_done%0d got %b want %b", i, ctl, C_DONE);
      end
      cyc();
    end
    req_valid = 1'b0;
    cyc();
  endtask

  task automatic test_misaligned();
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1;
      req_op    = (i == 0) ? 2'b00 : 2'b10;
      req_addr  = (i == 0) ? 32'h022 : 32'h013;
      m.ack     = 1'b1;
      m.rvalid  = 1'b1;
      @(negedge clk);
      vectors++;
      if (ctl !== C_ZERO) begin
        errors++;
        $display("FAIL mis_idle%0d got %b want %b", i, ctl, C_ZERO);
      end
      cyc();
      @(negedge clk);
      vectors++;
      if (ctl !== C_ERR) begin
        errors++;
        $display("FAIL mis_err%0d got %b want %b", i, ctl, C_ERR);
      end
      cyc();
      req_valid = 1'b0;
      cyc();
      @(negedge clk);
      vectors++;
      if (ctl !== C_ERR) begin
        errors++;
        $display("FAIL mis_sticky%0d got %b want %b", i, ctl, C_ERR);
      end
      cyc();
      do_reset("mis");
      @(negedge clk);
      vectors++;
      if (ctl !== C_ZERO) begin
        errors++;
        $display("FAIL mis_recover%0d got %b want %b", i, ctl, C_ZERO);
      end
      cyc();
    end
  endtask

  task automatic test_timeout(input bit acked);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_addr  = acked ? 32'h048 : 32'h040;
    cyc();
    for (int i = 0; i < 4; i++) begin
      m.ack = acked && (i == 0);
      @(negedge clk);
      vectors++;
      if (ctl !== ((i == 0 || !acked) ? C_S_LW : C_ACKED)) begin
        errors++;
        $display("FAIL tmo%0d_wait%0d got %b", acked, i, ctl);
      end
      cyc();
    end
    m.ack = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== C_ERR) begin
      errors++;
      $display("FAIL tmo%0d_err got %b want %b", acked, ctl, C_ERR);
    end
    cyc();
    do_reset("tmo");
  endtask

  task automatic test_timeout_edge();
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_addr  = 32'h044;
    model_rdata = 32'hCAFEF00D;
    exp_q.push_back(model_rdata);
    cyc();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== C_S_LW) begin
        errors++;
        $display("FAIL edge_wait%0d got %b want %b", i, ctl, C_S_LW);
      end
      cyc();
    end
    m.ack    = 1'b1;
    m.rvalid = 1'b1;
    m.rdata  = 32'hCAFEF00D;
    @(negedge clk);
    vectors++;
    if (ctl !== (C_S_LW | C_YUMI)) begin
      errors++;
      $display("FAIL edge_last got %b want %b", ctl, C_S_LW | C_YUMI);
    end
    cyc();
    m.ack    = 1'b0;
    m.rvalid = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== C_DONE) begin
      errors++;
      $display("FAIL edge_done got %b want %b", ctl, C_DONE);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_addr  = 32'h050;
    cyc();
    m.ack = 1'b1;
    cyc();
    m.ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== C_ACKED) begin
      errors++;
      $display("FAIL mid_acked got %b want %b", ctl, C_ACKED);
    end
    cyc();
    do_reset("mid");
  endtask

  initial begin
    n_reset   = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    m.ack     = 1'b0;
    m.rvalid  = 1'b0;
    m.rdata   = '0;
    test_reset();
    test_sw();
    test_lw_wait();
    test_lbu();
    test_sb();
    test_back_to_back();
    test_misaligned();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_timeout_edge();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/dmem_req_ctrl.md
Name: dmem_req_ctrl

Overview:
Data-memory request controller between the core's execute stage and data memory. Takes one LW/LBU/SW/SB request at a time, runs the two-phase valid/yumi handshake with memory (IDLE -> REQ_SENT -> REQ_ACKED), stalls the pipeline while the access is outstanding, and returns aligned, zero-extended load data. It also detects misaligned word accesses and hung memory, and reports both through a sticky error state.

Parameters:
ADDR_W, 12, data-memory byte-address width (matches data_mem_addr_width_gp)
TIMEOUT_CYC, 255, maximum cycles from entering REQ_SENT to completion; 0 disables the timeout
CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
clk  in  1  core clock
n_reset  in  1  asynchronous, active-low reset
req_valid_i  in  1  execute stage holds a memory instruction; held until done_o
req_op_i  in  2  opcode[1:0]: 00 LW, 01 LBU, 10 SW, 11 SB
req_addr_i  in  32  byte address (rs value); low ADDR_W bits used
req_wdata_i  in  32  store data (rd value)
stall_o  out  1  freeze fetch/decode/execute
done_o  out  1  one-cycle pulse; access complete, rdata_o valid
rdata_o  out  32  load result
err_o  out  1  sticky error indication
state_o  out  2  debug: 00 IDLE, 01 BUSY (REQ_SENT/REQ_ACKED/DONE), 11 ERR
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  32  mem_in_s.write_data
mem_valid_o  out  1  mem_in_s.valid
mem_wen_o  out  1  mem_in_s.wen
mem_byte_o  out  1  mem_in_s.byte_not_word
mem_yumi_o  out  1  mem_in_s.yumi; core consumes read response
mem_rdata_i  in  32  mem_out_s.read_data
mem_valid_i  in  1  mem_out_s.valid; read data present
mem_ack_i  in  1  mem_out_s.yumi; memory accepted command

Behaviour:
- Reset (asynchronous, n_reset=0): state IDLE, counter 0, latched registers 0. All outputs are 0.
- FSM states: IDLE, REQ_SENT, REQ_ACKED, DONE, ERR.
- IDLE:
  - If req_valid_i and the access is misaligned (LW/SW with addr[1:0]!=0): go to ERR. No memory request is issued.
  - Else if req_valid_i: latch op, addr[ADDR_W-1:0] and wdata; go to REQ_SENT.
  - For SB, the latched wdata is byte[7:0] replicated into all four lanes.
  - stall_o = req_valid_i & !misaligned (combinational).
- REQ_SENT:
  - mem_valid_o=1. mem_addr/wdata/wen/byte come from latched registers and are stable until ack.
  - mem_wen_o=1 for SW/SB. mem_byte_o=1 for LBU/SB.
  - Store with mem_ack_i -> DONE.
  - Load with mem_ack_i and mem_valid_i in the same cycle -> capture data, mem_yumi_o=1, go to DONE.
  - Load with mem_ack_i only -> REQ_ACKED.
  - stall_o=1.
- REQ_ACKED: mem_valid_o=0, stall_o=1. When mem_valid_i: mem_yumi_o=1 (combinational, same cycle), capture data, go to DONE.
- Load data capture:
  - LW: rdata_o = mem_rdata_i.
  - LBU: rdata_o = {24'b0, byte lane addr[1:0]}, little-endian (lane 0 = bits 7:0).
  - Stores leave rdata_o unchanged.
- DONE: lasts one cycle. done_o=1, stall_o=0. req_valid_i is ignored this cycle. Next state IDLE.
- mem_yumi_o is 0 in every state except as stated above. mem_valid_i seen in IDLE or DONE is not consumed.
- Timeout:
  - Counter clears on IDLE->REQ_SENT and increments each cycle in REQ_SENT/REQ_ACKED.
  - If TIMEOUT_CYC!=0 and the counter equals TIMEOUT_CYC without a completing event that cycle, go to ERR.
  - A completing event in the same cycle as the timeout wins: go to DONE.
- ERR: err_o=1, stall_o=1, all mem_* control outputs 0. Leaves ERR only on reset.
- Reset mid-access drops the request immediately. Memory-side cleanup is the memory's responsibility.
- Latency with no memory wait states:
  - Store: req cycle, SENT+ack, DONE = 3 cycles.
  - Load: the same if ack and valid coincide; +1 cycle per REQ_ACKED cycle.

Test Plan:
1. SW addr 0x010, data 0xDEADBEEF, mem_ack_i in first SENT cycle -> mem_valid_o=1 one cycle, wen=1, byte=0, addr=0x010; done_o pulses 2 cycles after req; stall_o high for 2 cycles.
2. LW addr 0x020, ack in SENT, mem_valid_i=1 with 0x12345678 three cycles later -> REQ_ACKED held 3 cycles, mem_yumi_o=1 only on the valid cycle, rdata_o=0x12345678 with done_o.
3. LBU addr 0x023, mem_rdata_i=0xAABBCCDD, ack and valid together -> rdata_o=0x000000AA, mem_byte_o=1.
4. SB addr 0x005, wdata 0x000000E7 -> mem_wdata_o=0xE7E7E7E7, byte=1, wen=1.
5. LW addr 0x022 -> no mem_valid_o, ERR next cycle, err_o=1, stall_o=1; n_reset pulse -> IDLE, err_o=0.
6. TIMEOUT_CYC=4, LW, memory never acks -> ERR after 4 SENT cycles. Repeat with ack arriving on cycle 4 -> DONE path, no error.
